alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Initiator/collector for the team's bit-serial 4-bit ALU, which resolves one result bit per clock over a 5-step cycle.
- Accepts one operation request over a valid/ready handshake and drives the ALU operands and opcode for exactly one full bit-serial pass.
- Parks the ALU on the idle opcode, samples the result and flags, and returns them over a valid/ready response handshake.
- Computes the expected result locally and flags any mismatch, so the block also serves as an in-system ALU checker.

Parameters:
HOLD_CYCLES, 5, consecutive clocks the opcode is held; equals the ALU's bit-serial step count.
SETTLE_CYCLES, 1, clocks with the idle opcode applied before sampling ALU outputs (min 1).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request (high only in IDLE).
req_a  in  4  operand A.
req_b  in  4  operand B.
req_op  in  3  opcode: 001 xor, 010 add, 011 and, 100 sub; all other codes are illegal.
alu_A  out  4  operand A to the ALU.
alu_B  out  4  operand B to the ALU.
alu_opCode  out  3  opcode to the ALU; 000 = idle.
alu_C  in  4  ALU result.
alu_Carry  in  1  ALU carry/borrow.
alu_Sign  in  1  ALU sign.
alu_Zero  in  1  ALU zero.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_c  out  4  captured result.
rsp_carry  out  1  captured carry.
rsp_sign  out  1  captured sign.
rsp_zero  out  1  captured zero.
rsp_mismatch  out  1  captured values differ from the locally computed expectation.
rsp_illegal  out  1  request carried an illegal opcode.
busy  out  1  state is not IDLE.

Behaviour:
- Reset, synchronous and active-high, overrides everything: state=IDLE, alu_opCode=000, alu_A=alu_B=0, rsp_valid=0, all rsp_* = 0, counter=0.
- FSM states: IDLE, ISSUE, SETTLE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge t, register operands and opcode.
  - Legal opcode: go to ISSUE. alu_A, alu_B and alu_opCode take the request values from t+1.
  - Illegal opcode: go to RESP at t+1 with rsp_c=0, rsp_carry=rsp_sign=rsp_zero=0, rsp_mismatch=0, rsp_illegal=1. The ALU is never driven.
- ISSUE:
  - alu_opCode is held constant for exactly HOLD_CYCLES clocks (t+1 .. t+HOLD_CYCLES). Counter counts 0..HOLD_CYCLES-1.
  - At the last count go to SETTLE. alu_opCode=000 from that edge; alu_A and alu_B keep their values.
- SETTLE:
  - Lasts SETTLE_CYCLES clocks.
  - On the final edge, sample alu_C and the three flags into rsp_*, set rsp_mismatch, clear rsp_illegal, and go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* are stable until the transfer.
  - On rsp_valid && rsp_ready, go to IDLE and drop rsp_valid next clock.
  - req_ready stays 0 throughout, so there is no overlap of requests.
- Latency, legal op with an immediately ready consumer: rsp_valid rises HOLD_CYCLES+SETTLE_CYCLES+1 clocks after acceptance (7 at defaults). Illegal op: 1 clock.
- Expected values, all widths 4-bit unsigned:
  - add: C=(A+B) mod 16, carry=(A+B>15).
  - sub: C=(A-B) mod 16, carry=borrow=(A<B).
  - and/xor: bitwise result, carry=0.
  - All ops: zero=(C==0), sign=C[3].
  - rsp_mismatch=1 if any of the four captured values differs from its expected value.
- Boundaries:
  - req_valid while busy is ignored (not accepted).
  - Reset mid-ISSUE returns alu_opCode to 000 on the next edge; no response is produced.
  - Request inputs changing after acceptance have no effect.
  - rsp_ready held low stalls indefinitely in RESP with outputs stable.
  - Back-to-back requests: the earliest next acceptance is the clock after the response transfer.

Test Plan:
- add A=0111 B=0001, rsp_ready=1 -> alu_opCode=010 for exactly 5 clocks then 000; rsp_valid at +7; rsp_c=1000 carry=0 sign=1 zero=0 mismatch=0.
- sub A=0011 B=0101 -> rsp_c=1110 carry=1 sign=1 zero=0; then add 1111+0001 -> rsp_c=0000 carry=1 zero=1.
- xor A=1010 B=1010 -> rsp_c=0000 zero=1 carry=0; and A=1100 B=1010 -> rsp_c=1000 sign=1.
- Illegal op 110 -> alu_opCode stays 000; rsp_valid next clock with rsp_illegal=1, rsp_c=0.
- rsp_ready low 10 clocks -> rsp_* stable, req_ready=0, a second req_valid is not accepted; accepted only after the transfer.
- reset asserted at the 3rd ISSUE clock -> next edge alu_opCode=000, busy=0, rsp_valid=0; a later add 0001+0001 -> rsp_c=0010. Forcing alu_C wrong at sample time -> rsp_mismatch=1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issues one request to the bit-serial 4-bit ALU and holds the opcode for a full pass.
// It then parks the ALU on the idle opcode and returns the sampled result with a local cross-check.
module alu_op_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 5,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic [2:0] req_op,
    output logic [3:0] alu_A,
    output logic [3:0] alu_B,
    output logic [2:0] alu_opCode,
    input  logic [3:0] alu_C,
    input  logic       alu_Carry,
    input  logic       alu_Sign,
    input  logic       alu_Zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_c,
    output logic       rsp_carry,
    output logic       rsp_sign,
    output logic       rsp_zero,
    output logic       rsp_mismatch,
    output logic       rsp_illegal,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_IDLE = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         a_q, a_d, b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [3:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [3:0]         rsp_c_q, rsp_c_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_sign_q, rsp_sign_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_mismatch_q, rsp_mismatch_d;
    logic               rsp_illegal_q, rsp_illegal_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;

    logic [4:0]         sum_w, diff_w;
    logic [3:0]         exp_c;
    logic               exp_carry;
    logic               req_legal;

    // Reference model of the ALU, evaluated on the latched request
    always_comb begin
        sum_w     = {1'b0, a_q} + {1'b0, b_q};
        diff_w    = {1'b0, a_q} - {1'b0, b_q};
        exp_c     = 4'b0000;
        exp_carry = 1'b0;
        case (op_q)
            OP_XOR: exp_c = a_q ^ b_q;
            OP_AND: exp_c = a_q & b_q;
            OP_ADD: begin
                exp_c     = sum_w[3:0];
                exp_carry = sum_w[4];
            end
            OP_SUB: begin
                exp_c     = diff_w[3:0];
                exp_carry = diff_w[4];
            end
            default: ;
        endcase
    end

    assign req_legal = (req_op == OP_XOR) || (req_op == OP_ADD) ||
                       (req_op == OP_AND) || (req_op == OP_SUB);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_c_d        = rsp_c_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_sign_d     = rsp_sign_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_mismatch_d = rsp_mismatch_q;
        rsp_illegal_d  = rsp_illegal_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d  = req_a;
                    b_d  = req_b;
                    op_d = req_op;
                    if (req_legal) begin
                        alu_a_d  = req_a;
                        alu_b_d  = req_b;
                        alu_op_d = req_op;
                        cnt_d    = '0;
                        state_d  = ISSUE;
                    end else begin
                        // Illegal opcode answers immediately without touching the ALU
                        rsp_c_d        = 4'b0000;
                        rsp_carry_d    = 1'b0;
                        rsp_sign_d     = 1'b0;
                        rsp_zero_d     = 1'b0;
                        rsp_mismatch_d = 1'b0;
                        rsp_illegal_d  = 1'b1;
                        rsp_valid_d    = 1'b1;
                        state_d        = RESP;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    alu_op_d = OP_IDLE;
                    cnt_d    = '0;
                    state_d  = SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    rsp_c_d        = alu_C;
                    rsp_carry_d    = alu_Carry;
                    rsp_sign_d     = alu_Sign;
                    rsp_zero_d     = alu_Zero;
                    rsp_mismatch_d = (alu_C != exp_c) || (alu_Carry != exp_carry) ||
                                     (alu_Sign != exp_c[3]) || (alu_Zero != (exp_c == 4'b0000));
                    rsp_illegal_d  = 1'b0;
                    rsp_valid_d    = 1'b1;
                    cnt_d          = '0;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            a_q            <= 4'b0000;
            b_q            <= 4'b0000;
            op_q           <= OP_IDLE;
            alu_a_q        <= 4'b0000;
            alu_b_q        <= 4'b0000;
            alu_op_q       <= OP_IDLE;
            rsp_valid_q    <= 1'b0;
            rsp_c_q        <= 4'b0000;
            rsp_carry_q    <= 1'b0;
            rsp_sign_q     <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_mismatch_q <= 1'b0;
            rsp_illegal_q  <= 1'b0;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_c_q        <= rsp_c_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_sign_q     <= rsp_sign_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_mismatch_q <= rsp_mismatch_d;
            rsp_illegal_q  <= rsp_illegal_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign busy         = busy_q;
    assign alu_A        = alu_a_q;
    assign alu_B        = alu_b_q;
    assign alu_opCode   = alu_op_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_c        = rsp_c_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_sign     = rsp_sign_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_mismatch = rsp_mismatch_q;
    assign rsp_illegal  = rsp_illegal_q;

endmodule
